// File: rtl/aq_axils_reduce_mc.sv
// aq_axils_reduce_mc
// AXI4-Lite register block for the multi-channel reduce datapath. Each channel
// owns shadow ORG_X/ORG_Y/CNV_X/CNV_Y registers which are copied to the active
// outputs together on a frame boundary after a COMMIT request, or continuously
// when BYPASS is set.
//
// Ports:
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*      write address/data/response channels (CACHE/PROT unused)
//   S_AXI_AR*/R*         read address/data channels (CACHE/PROT unused)
//   FRAME_START          single-cycle frame boundary pulse
//   ORG_X/ORG_Y/CNV_X/CNV_Y  active values, channel n at [n*FIELD_W +: FIELD_W]
//   COMMIT_DONE          one-cycle pulse when shadow values reach the outputs
module aq_axils_reduce_mc #(
  parameter int          NUM_CH  = 2,
  parameter int          FIELD_W = 16,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [31:0]               S_AXI_AWADDR,
  input  logic [3:0]                S_AXI_AWCACHE,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [31:0]               S_AXI_WDATA,
  input  logic [3:0]                S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  output logic [1:0]                S_AXI_BRESP,
  input  logic [31:0]               S_AXI_ARADDR,
  input  logic [3:0]                S_AXI_ARCACHE,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [31:0]               S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  input  logic                      FRAME_START,
  output logic [NUM_CH*FIELD_W-1:0] ORG_X,
  output logic [NUM_CH*FIELD_W-1:0] ORG_Y,
  output logic [NUM_CH*FIELD_W-1:0] CNV_X,
  output logic [NUM_CH*FIELD_W-1:0] CNV_Y,
  output logic                      COMMIT_DONE
);

  localparam int NREG = NUM_CH * 4;

  typedef enum logic [1:0] {IDLE, WCOLLECT, WRESP, RRESP} state_t;

  state_t             state_q, state_d;
  logic [7:2]         aw_addr_q, aw_addr_d;
  logic               aw_have_q, aw_have_d;
  logic [31:0]        w_data_q, w_data_d;
  logic [3:0]         w_strb_q, w_strb_d;
  logic               w_have_q, w_have_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               bypass_q, bypass_d;
  logic               pending_q, pending_d;
  logic               commit_done_q, commit_done_d;
  logic [FIELD_W-1:0] shadow_q [NREG];
  logic [FIELD_W-1:0] shadow_d [NREG];
  logic [FIELD_W-1:0] active_q [NREG];
  logic [FIELD_W-1:0] active_d [NREG];

  logic        wr_fire, rd_fire, copy;
  logic [7:2]  wr_addr, rd_addr;
  logic [31:0] wr_data, wr_mask, rd_val;
  logic [3:0]  wr_strb;
  logic        wr_is_ch, wr_is_ctrl, rd_is_ch, rd_ok;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWADDR[31:8], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:8],
                       S_AXI_ARADDR[1:0], S_AXI_AWCACHE, S_AXI_AWPROT,
                       S_AXI_ARCACHE, S_AXI_ARPROT, wr_data, wr_mask};

  // A write completes when the second of AW/W arrives; whichever half was
  // captured earlier comes from the holding registers, the other from the bus.
  always_comb begin
    wr_fire = ((state_q == IDLE) && S_AXI_AWVALID && S_AXI_WVALID) ||
              ((state_q == WCOLLECT) && ((aw_have_q && S_AXI_WVALID) ||
                                         (w_have_q && S_AXI_AWVALID)));
    rd_fire = (state_q == IDLE) && S_AXI_ARVALID && !S_AXI_AWVALID && !S_AXI_WVALID;
    wr_addr = aw_have_q ? aw_addr_q : S_AXI_AWADDR[7:2];
    wr_data = w_have_q ? w_data_q : S_AXI_WDATA;
    wr_strb = w_have_q ? w_strb_q : S_AXI_WSTRB;
    wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    wr_is_ch   = !wr_addr[7] && (int'(wr_addr[6:4]) < NUM_CH);
    wr_is_ctrl = (wr_addr == 6'b100000);
    rd_addr    = S_AXI_ARADDR[7:2];
    rd_is_ch   = !rd_addr[7] && (int'(rd_addr[6:4]) < NUM_CH);
    copy       = FRAME_START && pending_q;
  end

  // Read mux; addr[6:2] is directly the shadow index (channel*4 + field).
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    if (rd_is_ch) begin
      for (int i = 0; i < NREG; i++) begin
        if (int'(rd_addr[6:2]) == i) rd_val[FIELD_W-1:0] = shadow_q[i];
      end
    end else if (rd_addr == 6'b100000) begin
      rd_val = {30'd0, bypass_q, 1'b0};
    end else if (rd_addr == 6'b100001) begin
      rd_val = {31'd0, pending_q};
    end else if (rd_addr == 6'b100010) begin
      rd_val = VERSION;
    end else begin
      rd_ok = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a pending write always beats a simultaneous read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID)      state_d = WRESP;
        else if (S_AXI_AWVALID || S_AXI_WVALID) state_d = WCOLLECT;
        else if (S_AXI_ARVALID)                 state_d = RRESP;
      end
      WCOLLECT: if (wr_fire)        state_d = WRESP;
      WRESP:    if (S_AXI_BREADY)   state_d = IDLE;
      RRESP:    if (S_AXI_RREADY)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Handshake outputs; in WCOLLECT only the missing channel is offered.
  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (state_q)
      IDLE: begin
        S_AXI_AWREADY = 1'b1;
        S_AXI_WREADY  = 1'b1;
        S_AXI_ARREADY = !S_AXI_AWVALID && !S_AXI_WVALID;
      end
      WCOLLECT: begin
        S_AXI_AWREADY = !aw_have_q;
        S_AXI_WREADY  = !w_have_q;
      end
      WRESP:   S_AXI_BVALID = 1'b1;
      RRESP:   S_AXI_RVALID = 1'b1;
      default: ;
    endcase
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign COMMIT_DONE = commit_done_q;

  // Channel capture, responses and the register file. The copy reads
  // shadow_q, so a shadow write in the copy cycle lands only in the shadow.
  always_comb begin
    aw_addr_d = aw_addr_q;
    aw_have_d = aw_have_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_have_d  = w_have_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bypass_d  = bypass_q;
    pending_d = pending_q;
    if ((state_q == IDLE) && S_AXI_AWVALID && !S_AXI_WVALID) begin
      aw_addr_d = S_AXI_AWADDR[7:2];
      aw_have_d = 1'b1;
    end
    if ((state_q == IDLE) && S_AXI_WVALID && !S_AXI_AWVALID) begin
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
      w_have_d = 1'b1;
    end
    if (wr_fire) begin
      aw_have_d = 1'b0;
      w_have_d  = 1'b0;
      bresp_d   = (wr_is_ch || wr_is_ctrl) ? 2'b00 : 2'b10;
    end
    if (rd_fire) begin
      rdata_d = rd_val;
      rresp_d = rd_ok ? 2'b00 : 2'b10;
    end
    if (copy) pending_d = 1'b0;
    // A COMMIT arriving with FRAME_START re-arms for the next frame.
    if (wr_fire && wr_is_ctrl && wr_strb[0]) begin
      bypass_d = wr_data[1];
      if (wr_data[0]) pending_d = 1'b1;
    end
    commit_done_d = copy && !bypass_q;
    for (int i = 0; i < NREG; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_fire && wr_is_ch && (int'(wr_addr[6:2]) == i)) begin
        shadow_d[i] = (shadow_q[i] & ~wr_mask[FIELD_W-1:0]) |
                      (wr_data[FIELD_W-1:0] & wr_mask[FIELD_W-1:0]);
      end
      active_d[i] = (bypass_q || copy) ? shadow_q[i] : active_q[i];
    end
  end

  // Datapath registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_addr_q     <= '0;
      aw_have_q     <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      w_have_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rdata_q       <= '0;
      rresp_q       <= 2'b00;
      bypass_q      <= 1'b0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      aw_addr_q     <= aw_addr_d;
      aw_have_q     <= aw_have_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      w_have_q      <= w_have_d;
      bresp_q       <= bresp_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
      bypass_q      <= bypass_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  // Flatten the active registers onto the per-field output buses.
  always_comb begin
    ORG_X = '0;
    ORG_Y = '0;
    CNV_X = '0;
    CNV_Y = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ORG_X[c*FIELD_W +: FIELD_W] = active_q[c*4 + 0];
      ORG_Y[c*FIELD_W +: FIELD_W] = active_q[c*4 + 1];
      CNV_X[c*FIELD_W +: FIELD_W] = active_q[c*4 + 2];
      CNV_Y[c*FIELD_W +: FIELD_W] = active_q[c*4 + 3];
    end
  end

endmodule

// File: doc/aq_axils_reduce_mc.md
Name: aq_axils_reduce_mc

Overview:
- AXI4-Lite slave register block for the multi-channel reduce (scaler) datapath; next generation of the single-channel ORG/CNV register file.
- Holds NUM_CH sets of ORG_X/ORG_Y/CNV_X/CNV_Y as shadow registers and transfers them to active outputs atomically at a frame boundary (or immediately in bypass mode).
- Adds byte-strobe writes, independent AW/W arrival order, and SLVERR on unmapped or read-only accesses.

Parameters:
- NUM_CH, 2, channel count (1..8); channel n registers at offset n*0x10
- FIELD_W, 16, width of each size field (1..32)
- VERSION, 32'h0002_0000, value returned by the VERSION register

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; asynchronous, active-low
- S_AXI_AWADDR/AWCACHE/AWPROT/AWVALID/AWREADY  in/in/in/in/out  32/4/3/1/1  write address channel; CACHE/PROT ignored
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
- S_AXI_BVALID/BREADY/BRESP  out/in/out  1/1/2  write response
- S_AXI_ARADDR/ARCACHE/ARPROT/ARVALID/ARREADY  in/in/in/in/out  32/4/3/1/1  read address; CACHE/PROT ignored
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data
- FRAME_START  in  1  single-cycle frame boundary pulse from the video timing
- ORG_X, ORG_Y, CNV_X, CNV_Y  out  NUM_CH*FIELD_W each  active values; channel n at [n*FIELD_W +: FIELD_W]
- COMMIT_DONE  out  1  one-cycle pulse when shadow values are copied to the active outputs

Behaviour:
- Register map (addr[7:0], addr[1:0] ignored): ch n base n*0x10: +0 ORG_X, +4 ORG_Y, +8 CNV_X, +C CNV_Y (RW shadow, FIELD_W LSBs; upper bits read 0). 0x80 CTRL: bit0 COMMIT (W1S, reads 0), bit1 BYPASS (RW). 0x84 STATUS (RO): bit0 PENDING. 0x88 VERSION (RO). addr[31:8] is not decoded.
- Unmapped addresses (including channel ≥ NUM_CH) and writes to 0x84/0x88 -> RESP=2'b10, no state change; unmapped reads return RDATA=0.
- Byte strobes apply to every RW register; bits beyond FIELD_W are discarded.
- Reset: all shadow/active regs 0, BYPASS=0, PENDING=0, all VALID/READY outputs 0 except AWREADY/WREADY/ARREADY=1 in IDLE, RDATA=0, RESP=0, COMMIT_DONE=0.
- FSM: IDLE, WCOLLECT, WRESP, RRESP.
  - IDLE: AWREADY=WREADY=ARREADY=1.
    - Any AW or W handshake captures it; both in the same cycle -> WRESP next cycle with the write performed at that edge.
    - Only one captured -> WCOLLECT.
    - ARVALID only (no AWVALID/WVALID) -> capture and go to RRESP. Write wins when AW/W and AR are valid together; ARREADY=0 in that cycle.
  - WCOLLECT: READY asserted only for the missing channel; on its handshake, perform the write and go to WRESP. ARREADY=0.
  - WRESP: BVALID=1 with BRESP held until BREADY, then IDLE. Write latency is 1 cycle from the last of AW/W to BVALID.
  - RRESP: RVALID=1; RDATA/RRESP are registered at AR accept and held stable until RREADY, then IDLE. Read latency is 1 cycle.
- Commit:
  - Writing CTRL with bit0=1 (strobe byte0) sets PENDING.
  - On a FRAME_START with PENDING=1: active <= shadow for all channels, PENDING cleared, COMMIT_DONE pulses in the next cycle.
  - A COMMIT write in the same cycle as FRAME_START sets PENDING; the copy happens on the following FRAME_START.
  - A shadow write in the same cycle as the copy: the copy takes the pre-write shadow value.
- BYPASS=1: active follows shadow every cycle (1-cycle lag); PENDING and COMMIT are still tracked; COMMIT_DONE never pulses.
- Asynchronous reset mid-transaction aborts it: no B/R response is issued and registers return to reset values.

Test Plan:
- Reset, then read 0x88 -> RDATA=32'h0002_0000, RRESP=0; read 0x84 -> 0; all outputs 0.
- Write ch1 ORG_X (0x10)=0x1234_0280, W before AW by 3 cycles -> BRESP=0; readback 0x0000_0280; ORG_X[31:16] stays 0 until commit.
- Write 0x80=1, then FRAME_START -> ORG_X[31:16]=0x0280, COMMIT_DONE pulses once, STATUS=0 afterwards.
- Write 0x0C with WSTRB=4'b0010, data 0xAB00 over an existing 0x1111 -> readback 0xAB11.
- With NUM_CH=2: read 0x20 -> RRESP=2'b10, RDATA=0; write 0x84 -> BRESP=2'b10; hold BREADY low 5 cycles -> BVALID/BRESP stay stable.
- AWVALID, WVALID and ARVALID all high together -> write completes first, read accepted only after BREADY; BYPASS=1 then write 0x08=0x0100 -> CNV_X[15:0]=0x0100 two cycles after the W handshake with no FRAME_START.
